// File: rtl/mod_exp_engine.sv
// ============================================================================
// Module : mod_exp_engine
// Brief  : Constant-latency modular exponentiation, result = base^exponent mod modulus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mod_exp_engine #(
    parameter int WIDTH = 128,
    parameter int EXP_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [EXP_W-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int KW = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] base_q;
    logic [WIDTH-1:0] mod_q;
    logic [EXP_W-1:0] exp_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   r;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k;

    logic [WIDTH-1:0] mul_b;
    logic             mul_a_bit;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   dbl_red;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_next;
    logic             last_cycle;
    logic             exp_bit;

    // One interleaved modmul iteration; r < m is kept so every intermediate fits WIDTH+1 bits.
    always_comb begin
        mul_b      = (state == MUL) ? base_q : acc;
        mul_a_bit  = acc[cnt];
        m_ext      = {1'b0, mod_q};
        dbl        = r << 1;
        dbl_red    = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
        sum        = dbl_red + (mul_a_bit ? {1'b0, mul_b} : '0);
        r_next     = (sum >= m_ext) ? (sum - m_ext) : sum;
        last_cycle = (cnt == '0);
        exp_bit    = exp_q[k];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            base_q <= '0;
            mod_q  <= '0;
            exp_q  <= '0;
            acc    <= '0;
            r      <= '0;
            cnt    <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        base_q <= base;
                        exp_q  <= exponent;
                        mod_q  <= modulus;
                        err    <= 1'b0;
                        busy   <= 1'b1;
                        state  <= CHECK;
                    end
                end

                CHECK: begin
                    if ((mod_q == '0) || (base_q >= mod_q)) begin
                        err    <= 1'b1;
                        done   <= 1'b1;
                        result <= '0;
                        state  <= FIN;
                    end else begin
                        acc   <= (mod_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                        k     <= KW'(EXP_W - 1);
                        cnt   <= CW'(WIDTH - 1);
                        r     <= '0;
                        state <= SQR;
                    end
                end

                SQR: begin
                    if (last_cycle) begin
                        acc   <= r_next[WIDTH-1:0];
                        r     <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        state <= MUL;
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - 1'b1;
                    end
                end

                MUL: begin
                    if (last_cycle) begin
                        r   <= '0;
                        cnt <= CW'(WIDTH - 1);
                        // Multiply always runs; the exponent bit only selects whether it is kept.
                        if (exp_bit) begin
                            acc <= r_next[WIDTH-1:0];
                        end
                        if (k == '0) begin
                            done   <= 1'b1;
                            result <= exp_bit ? r_next[WIDTH-1:0] : acc;
                            state  <= FIN;
                        end else begin
                            k     <= k - 1'b1;
                            state <= SQR;
                        end
                    end else begin
                        r   <= r_next;
                        cnt <= cnt - 1'b1;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
// ============================================================================
// Module : tb_mod_exp_engine
// Brief  : Directed vector bench for mod_exp_engine plus an RSA round trip.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mod_exp_engine;

    localparam int WIDTH = 16;
    localparam int EXP_W = 8;
    localparam int LAT_OK  = 2 + 2 * EXP_W * WIDTH;
    localparam int RSA_EW  = 12;
    localparam int LAT_RSA = 2 + 2 * RSA_EW * WIDTH;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] base;
    logic [EXP_W-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;

    logic              es_start, ds_start;
    logic [WIDTH-1:0]  es_base, ds_base, es_mod, ds_mod;
    logic [RSA_EW-1:0] es_exp, ds_exp;
    logic              es_busy, ds_busy, es_done, ds_done, es_err, ds_err;
    logic [WIDTH-1:0]  es_res, ds_res;

    int total = 0;
    int bad   = 0;

    mod_exp_engine #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .exponent(exponent),
        .modulus(modulus), .busy(busy), .done(done), .err(err), .result(result)
    );

    mod_exp_engine #(.WIDTH(WIDTH), .EXP_W(RSA_EW)) enc (
        .clk(clk), .reset(reset), .start(es_start), .base(es_base), .exponent(es_exp),
        .modulus(es_mod), .busy(es_busy), .done(es_done), .err(es_err), .result(es_res)
    );

    mod_exp_engine #(.WIDTH(WIDTH), .EXP_W(RSA_EW)) dec (
        .clk(clk), .reset(reset), .start(ds_start), .base(ds_base), .exponent(ds_exp),
        .modulus(ds_mod), .busy(ds_busy), .done(ds_done), .err(ds_err), .result(ds_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] b;
        logic [EXP_W-1:0] e;
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] res;
        logic             er;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] b, input logic [EXP_W-1:0] e,
                         input logic [WIDTH-1:0] m, output logic [WIDTH-1:0] r,
                         output logic er, output int lat);
        @(negedge clk);
        base = b; exponent = e; modulus = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        chk("busy_after_accept", busy, 1);
        chk("err_cleared_on_accept", err, 0);
        while (!done && lat < 1000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("done_seen", done, 1);
        r  = result;
        er = err;
        @(posedge clk); #1;
        chk("done_single_pulse", done, 0);
        chk("busy_drops", busy, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] r;
        logic             er;
        int               lat;
        int               dones;

        vecs[0]  = '{b: 16'd4,  e: 8'd13,  m: 16'd497,  res: 16'd445, er: 1'b0};
        vecs[1]  = '{b: 16'd7,  e: 8'd0,   m: 16'd13,   res: 16'd1,   er: 1'b0};
        vecs[2]  = '{b: 16'd9,  e: 8'd5,   m: 16'd1,    res: 16'd0,   er: 1'b1};
        vecs[3]  = '{b: 16'd20, e: 8'd3,   m: 16'd7,    res: 16'd0,   er: 1'b1};
        vecs[4]  = '{b: 16'd5,  e: 8'd3,   m: 16'd0,    res: 16'd0,   er: 1'b1};
        vecs[5]  = '{b: 16'd3,  e: 8'd200, m: 16'd1000, res: 16'd1,   er: 1'b0};
        vecs[6]  = '{b: 16'd2,  e: 8'd10,  m: 16'd1000, res: 16'd24,  er: 1'b0};
        vecs[7]  = '{b: 16'd0,  e: 8'd5,   m: 16'd11,   res: 16'd0,   er: 1'b0};
        vecs[8]  = '{b: 16'd10, e: 8'd3,   m: 16'd11,   res: 16'd10,  er: 1'b0};
        vecs[9]  = '{b: 16'd13, e: 8'd2,   m: 16'd13,   res: 16'd0,   er: 1'b1};
        vecs[10] = '{b: 16'd0,  e: 8'd5,   m: 16'd1,    res: 16'd0,   er: 1'b0};
        vecs[11] = '{b: 16'd12, e: 8'd255, m: 16'd13,   res: 16'd12,  er: 1'b0};
        // base=9 with modulus=1 is base>=modulus, hence an input error; the
        // spec's mod-1 case is exercised by vector 10 (0^5 mod 1).

        reset = 1'b1; start = 1'b0; base = '0; exponent = '0; modulus = '0;
        es_start = 1'b0; es_base = '0; es_exp = '0; es_mod = '0;
        ds_start = 1'b0; ds_base = '0; ds_exp = '0; ds_mod = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_result", result, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].b, vecs[i].e, vecs[i].m, r, er, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_err", i), er, vecs[i].er);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].er ? 2 : LAT_OK);
        end

        // Start pulses while busy are dropped and operand changes are not seen.
        @(negedge clk);
        base = 16'd2; exponent = 8'd10; modulus = 16'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c < 200 && (c % 40) == 10) begin
                start = 1'b1; base = 16'd7; exponent = 8'd255; modulus = 16'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("busy_start_one_done", dones, 1);
        chk("busy_start_result", result, 24);
        chk("busy_start_err", err, 0);

        // Reset mid-operation aborts with no later done.
        @(negedge clk);
        base = 16'd4; exponent = 8'd13; modulus = 16'd497; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", dones, 0);
        do_op(16'd4, 8'd13, 16'd497, r, er, lat);
        chk("after_abort_result", r, 445);
        chk("after_abort_latency", lat, LAT_OK);

        // RSA round trip: p=61, q=53, n=3233, e=17, d=2753, message 65.
        @(negedge clk);
        es_base = 16'd65; es_exp = 12'd17; es_mod = 16'd3233; es_start = 1'b1;
        @(posedge clk); #1;
        es_start = 1'b0;
        lat = 1;
        while (!es_done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsa_enc_done", es_done, 1);
        chk("rsa_enc_latency", lat, LAT_RSA);
        chk("rsa_cipher", es_res, 2790);
        chk("rsa_enc_err", es_err, 0);
        @(negedge clk);
        ds_base = es_res; ds_exp = 12'd2753; ds_mod = 16'd3233; ds_start = 1'b1;
        @(posedge clk); #1;
        ds_start = 1'b0;
        lat = 1;
        while (!ds_done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsa_dec_done", ds_done, 1);
        chk("rsa_plain", ds_res, 65);
        chk("rsa_dec_err", ds_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
